current_instruction_register: RTL and testbench
===============================================

Name: current_instruction_register

Overview:
- Holds the instruction word currently being executed by the ECO32 CPU.
- Loaded from the bus read data during the fetch phase under control of the CPU control FSM; held for all following execute cycles.
- Provides the raw word plus combinational field extraction (opcode, register indices, immediates) for the decode and datapath stages.

Parameters:
- RESET_VALUE, 32'h00000000, register contents after reset.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- writeEnable  input  1  load strobe; when high, the register captures busReadData at the next rising clock edge.
- busReadData  input  32  instruction word from the memory bus.
- currentInstruction  output  32  registered instruction word.
- instructionValid  output  1  high once at least one load has occurred since reset.
- opcode  output  6  currentInstruction[31:26].
- rx  output  5  currentInstruction[25:21].
- ry  output  5  currentInstruction[20:16].
- rz  output  5  currentInstruction[15:11].
- immediate16  output  16  currentInstruction[15:0].
- immediate16SignExtended  output  32  immediate16 sign-extended from bit 15.
- immediate16ZeroExtended  output  32  immediate16 zero-extended.
- offset26  output  26  currentInstruction[25:0], the jump/branch offset field.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, resetN).
- resetN low, at any time and regardless of the clock:
  - currentInstruction = RESET_VALUE.
  - instructionValid = 0.
  - Reset dominates writeEnable.
- Rising clock edge with resetN high:
  - writeEnable = 1: currentInstruction <= busReadData and instructionValid <= 1.
  - writeEnable = 0: both hold their values.
- Latency: one clock from busReadData/writeEnable to currentInstruction. There is no combinational path from busReadData to any output.
- Back-to-back loads on consecutive cycles are allowed; each edge captures the current busReadData.
- All field outputs are purely combinational slices or extensions of the stored register, never of busReadData.
  - They change only when the register changes.
  - During reset they reflect RESET_VALUE.
- X on busReadData while writeEnable = 0 has no effect on any output.
- Deassertion of resetN is synchronised by the system reset generator outside this block; no internal synchronizer is used.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - Field bit-position constants: OPCODE_MSB/LSB = 31/26, RX = 25/21, RY = 20/16, RZ = 15/11, IMM16 = 15/0, OFFSET26 = 25/0.
  - Width constants: INSTRUCTION_WIDTH = 32, REGISTER_INDEX_WIDTH = 5, OPCODE_WIDTH = 6.
- Single module; no sub-module. Field extraction stays inline as continuous assignments.

Test Plan:
- Reset: assert resetN low with writeEnable = 1 and busReadData = 32'hFFFFFFFF -> currentInstruction = 0, instructionValid = 0, opcode = 0, immediate16SignExtended = 0.
- Load 1: release reset; writeEnable = 1, busReadData = 32'h12345678, one clock -> currentInstruction = 32'h12345678 and instructionValid = 1. Fields:
  - opcode = 6'h04, rx = 5'd17, ry = 5'd20, rz = 5'd10.
  - immediate16 = 16'h5678, immediate16SignExtended = 32'h00005678, offset26 = 26'h2345678.
- Load 2: writeEnable held 1, busReadData = 32'hABCDABCD, one clock -> currentInstruction = 32'hABCDABCD. Extensions:
  - immediate16SignExtended = 32'hFFFFABCD.
  - immediate16ZeroExtended = 32'h0000ABCD.
- Hold: writeEnable = 0, busReadData = 32'h01010101, several clocks -> currentInstruction stays 32'hABCDABCD and all fields are unchanged.
- Latency: change busReadData mid-cycle with writeEnable = 1 -> outputs stay unchanged until the next rising edge.
- Async reset mid-operation: pull resetN low between clock edges after a load -> currentInstruction = 0 and instructionValid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/current_instruction_register_pkg.sv
// Shared instruction-word layout for the ECO32 CPU: field bit positions, widths
// and the immediate extension helpers used by the decode stage.
package current_instruction_register_pkg;

    localparam int unsigned INSTRUCTION_WIDTH    = 32;
    localparam int unsigned REGISTER_INDEX_WIDTH = 5;
    localparam int unsigned OPCODE_WIDTH         = 6;
    localparam int unsigned IMMEDIATE_WIDTH      = 16;
    localparam int unsigned OFFSET_WIDTH         = 26;

    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 26;
    localparam int unsigned RX_MSB       = 25;
    localparam int unsigned RX_LSB       = 21;
    localparam int unsigned RY_MSB       = 20;
    localparam int unsigned RY_LSB       = 16;
    localparam int unsigned RZ_MSB       = 15;
    localparam int unsigned RZ_LSB       = 11;
    localparam int unsigned IMM16_MSB    = 15;
    localparam int unsigned IMM16_LSB    = 0;
    localparam int unsigned OFFSET26_MSB = 25;
    localparam int unsigned OFFSET26_LSB = 0;

    function automatic logic [INSTRUCTION_WIDTH-1:0] sign_extend_imm16(
        input logic [IMMEDIATE_WIDTH-1:0] imm
    );
        return {{(INSTRUCTION_WIDTH-IMMEDIATE_WIDTH){imm[IMMEDIATE_WIDTH-1]}}, imm};
    endfunction

    function automatic logic [INSTRUCTION_WIDTH-1:0] zero_extend_imm16(
        input logic [IMMEDIATE_WIDTH-1:0] imm
    );
        return {{(INSTRUCTION_WIDTH-IMMEDIATE_WIDTH){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/current_instruction_register.sv
// Current instruction register: captures the fetched word on writeEnable and
// exposes the raw word plus decoded fields, all derived from the stored value.
module current_instruction_register
    import current_instruction_register_pkg::*;
#(
    parameter logic [INSTRUCTION_WIDTH-1:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                            clock,
    input  logic                            resetN,
    input  logic                            writeEnable,
    input  logic [INSTRUCTION_WIDTH-1:0]    busReadData,
    output logic [INSTRUCTION_WIDTH-1:0]    currentInstruction,
    output logic                            instructionValid,
    output logic [OPCODE_WIDTH-1:0]         opcode,
    output logic [REGISTER_INDEX_WIDTH-1:0] rx,
    output logic [REGISTER_INDEX_WIDTH-1:0] ry,
    output logic [REGISTER_INDEX_WIDTH-1:0] rz,
    output logic [IMMEDIATE_WIDTH-1:0]      immediate16,
    output logic [INSTRUCTION_WIDTH-1:0]    immediate16SignExtended,
    output logic [INSTRUCTION_WIDTH-1:0]    immediate16ZeroExtended,
    output logic [OFFSET_WIDTH-1:0]         offset26
);

    logic [INSTRUCTION_WIDTH-1:0] r_instruction;
    logic                         r_valid;
    logic [IMMEDIATE_WIDTH-1:0]   w_imm16;

    // Instruction latch; reset wins over a pending load.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_instruction <= RESET_VALUE;
            r_valid       <= 1'b0;
        end else if (writeEnable) begin
            r_instruction <= busReadData;
            r_valid       <= 1'b1;
        end
    end

    // Fields come from the stored word only, never from the bus.
    assign w_imm16                 = r_instruction[IMM16_MSB:IMM16_LSB];
    assign currentInstruction      = r_instruction;
    assign instructionValid        = r_valid;
    assign opcode                  = r_instruction[OPCODE_MSB:OPCODE_LSB];
    assign rx                      = r_instruction[RX_MSB:RX_LSB];
    assign ry                      = r_instruction[RY_MSB:RY_LSB];
    assign rz                      = r_instruction[RZ_MSB:RZ_LSB];
    assign immediate16             = w_imm16;
    assign immediate16SignExtended = sign_extend_imm16(w_imm16);
    assign immediate16ZeroExtended = zero_extend_imm16(w_imm16);
    assign offset26                = r_instruction[OFFSET26_MSB:OFFSET26_LSB];

endmodule

// File: tb/tb_current_instruction_register.sv
// Directed self-checking bench for current_instruction_register.
module tb_current_instruction_register;

    logic        clock;
    logic        resetN;
    logic        writeEnable;
    logic [31:0] busReadData;
    logic [31:0] currentInstruction;
    logic        instructionValid;
    logic [5:0]  opcode;
    logic [4:0]  rx;
    logic [4:0]  ry;
    logic [4:0]  rz;
    logic [15:0] immediate16;
    logic [31:0] immediate16SignExtended;
    logic [31:0] immediate16ZeroExtended;
    logic [25:0] offset26;

    int unsigned n_compared;
    int unsigned n_mismatched;

    current_instruction_register dut (
        .clock                   (clock),
        .resetN                  (resetN),
        .writeEnable             (writeEnable),
        .busReadData             (busReadData),
        .currentInstruction      (currentInstruction),
        .instructionValid        (instructionValid),
        .opcode                  (opcode),
        .rx                      (rx),
        .ry                      (ry),
        .rz                      (rz),
        .immediate16             (immediate16),
        .immediate16SignExtended (immediate16SignExtended),
        .immediate16ZeroExtended (immediate16ZeroExtended),
        .offset26                (offset26)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Full field set for a stored word, with expected values given by hand.
    task automatic check_fields(input string tag, input logic [31:0] cur,
                                input logic valid, input logic [5:0] op,
                                input logic [4:0] x, input logic [4:0] y,
                                input logic [4:0] z, input logic [15:0] imm,
                                input logic [31:0] sext, input logic [31:0] zext,
                                input logic [25:0] off);
        check_value({tag, ".cur"},   currentInstruction, cur);
        check_value({tag, ".valid"}, 32'(instructionValid), 32'(valid));
        check_value({tag, ".op"},    32'(opcode), 32'(op));
        check_value({tag, ".rx"},    32'(rx), 32'(x));
        check_value({tag, ".ry"},    32'(ry), 32'(y));
        check_value({tag, ".rz"},    32'(rz), 32'(z));
        check_value({tag, ".imm"},   32'(immediate16), 32'(imm));
        check_value({tag, ".sext"},  immediate16SignExtended, sext);
        check_value({tag, ".zext"},  immediate16ZeroExtended, zext);
        check_value({tag, ".off"},   32'(offset26), 32'(off));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Reset held across clock edges while a load is requested.
        resetN      = 1'b0;
        writeEnable = 1'b1;
        busReadData = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        check_fields("reset", 32'h0, 1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0,
                     32'h0, 32'h0, 26'h0);

        // Load 1.
        resetN      = 1'b1;
        busReadData = 32'h1234_5678;
        @(negedge clock);
        check_fields("load1", 32'h1234_5678, 1'b1, 6'h04, 5'd17, 5'd20, 5'd10,
                     16'h5678, 32'h0000_5678, 32'h0000_5678, 26'h234_5678);

        // Load 2, back to back.
        busReadData = 32'hABCD_ABCD;
        @(negedge clock);
        check_fields("load2", 32'hABCD_ABCD, 1'b1, 6'h2A, 5'd30, 5'd13, 5'd21,
                     16'hABCD, 32'hFFFF_ABCD, 32'h0000_ABCD, 26'h3CD_ABCD);

        // Hold with a different bus value.
        writeEnable = 1'b0;
        busReadData = 32'h0101_0101;
        repeat (3) @(negedge clock);
        check_fields("hold", 32'hABCD_ABCD, 1'b1, 6'h2A, 5'd30, 5'd13, 5'd21,
                     16'hABCD, 32'hFFFF_ABCD, 32'h0000_ABCD, 26'h3CD_ABCD);

        // Unknown bus data while not loading.
        busReadData = 32'hxxxx_xxxx;
        repeat (2) @(negedge clock);
        check_value("hold_x.cur", currentInstruction, 32'hABCD_ABCD);
        check_value("hold_x.sext", immediate16SignExtended, 32'hFFFF_ABCD);

        // Latency: bus changes mid-cycle must not reach outputs before the edge.
        writeEnable = 1'b1;
        busReadData = 32'hCAFE_F00D;
        #2;
        check_value("lat_pre1.cur", currentInstruction, 32'hABCD_ABCD);
        busReadData = 32'h0F0F_1234;
        #1;
        check_value("lat_pre2.cur", currentInstruction, 32'hABCD_ABCD);
        check_value("lat_pre2.imm", 32'(immediate16), 32'h0000_ABCD);
        @(negedge clock);
        check_fields("lat_post", 32'h0F0F_1234, 1'b1, 6'h03, 5'd24, 5'd15, 5'd2,
                     16'h1234, 32'h0000_1234, 32'h0000_1234, 26'h30F_1234);

        // Asynchronous reset between edges.
        #2;
        resetN = 1'b0;
        #1;
        check_fields("async_rst", 32'h0, 1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0,
                     32'h0, 32'h0, 26'h0);
        @(negedge clock);
        check_value("rst_hold.cur", currentInstruction, 32'h0);

        // Recovery load after reset.
        busReadData = 32'h8000_8000;
        resetN      = 1'b1;
        @(negedge clock);
        check_fields("reload", 32'h8000_8000, 1'b1, 6'h20, 5'd0, 5'd0, 5'd16,
                     16'h8000, 32'hFFFF_8000, 32'h0000_8000, 26'h000_8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
